// File: rtl/clock_divider.sv
// Integer clock divider producing a 50% duty divided clock and a one-cycle tick
// aligned to each divided-clock rising edge. The ratio is fixed at elaboration.
module clock_divider #(
  parameter int DIV_FACTOR = 10
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out,
  output logic tick
);

  if (DIV_FACTOR < 1 || DIV_FACTOR > 65535) begin : g_bad_factor
    $error("clock_divider: DIV_FACTOR=%0d is outside the legal range 1..65535", DIV_FACTOR);
    assign clk_out = 1'b0;
    assign tick    = 1'b0;

  end else if (DIV_FACTOR == 1) begin : g_bypass
    // Divide-by-one passes the clock straight through, gated by reset.
    assign clk_out = clk & rst;
    assign tick    = rst;

  end else begin : g_div
    localparam int W = $clog2(DIV_FACTOR);
    localparam int H = DIV_FACTOR / 2;
    localparam logic [W-1:0] LAST = W'(DIV_FACTOR - 1);
    localparam logic [W-1:0] RISE = W'(H - 1);

    logic [W-1:0] cnt;
    logic         hi;
    logic         tick_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt    <= '0;
        hi     <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt    <= (cnt == LAST) ? '0 : cnt + W'(1);
        tick_q <= (cnt == RISE);
        if (cnt == RISE)
          hi <= 1'b1;
        else if (cnt == LAST)
          hi <= 1'b0;
      end
    end

    assign tick = tick_q;

    if (DIV_FACTOR % 2 == 1) begin : g_odd
      // hi stays up through the whole wrap cycle; this negedge flag trims the
      // last half period so high and low phases match. It is already set when
      // hi falls, so the AND cannot glitch.
      logic fall;

      always_ff @(negedge clk or negedge rst) begin
        if (!rst)
          fall <= 1'b0;
        else
          fall <= (cnt == LAST);
      end

      assign clk_out = hi & ~fall;
    end else begin : g_even
      assign clk_out = hi;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: N = 10, 5, 3, 2 and 1 share one clock and
// reset; outputs are sampled at absolute times away from the clock edges.
module tb_clock_divider;
  timeunit 1ns;
  timeprecision 1ns;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c10, t10, c5, t5, c3, t3, c2, t2, c1, t1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;  // rising edges at 5, 15, 25 ...

  clock_divider #(.DIV_FACTOR(10)) u_div10 (.clk(clk), .rst(rst), .clk_out(c10), .tick(t10));
  clock_divider #(.DIV_FACTOR(5))  u_div5  (.clk(clk), .rst(rst), .clk_out(c5),  .tick(t5));
  clock_divider #(.DIV_FACTOR(3))  u_div3  (.clk(clk), .rst(rst), .clk_out(c3),  .tick(t3));
  clock_divider #(.DIV_FACTOR(2))  u_div2  (.clk(clk), .rst(rst), .clk_out(c2),  .tick(t2));
  clock_divider #(.DIV_FACTOR(1))  u_div1  (.clk(clk), .rst(rst), .clk_out(c1),  .tick(t1));

  task automatic at(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  initial begin
    at(2);
    check("rst_c10", c10, 1'b0);
    check("rst_t10", t10, 1'b0);
    check("rst_c5",  c5,  1'b0);
    check("rst_t2",  t2,  1'b0);
    at(7);  // clk high, reset still asserted
    check("rst_c1_clk_high", c1, 1'b0);
    check("rst_t1", t1, 1'b0);
    check("rst_c3", c3, 1'b0);

    at(10);
    rst = 1'b1;

    at(12);
    check("n1_clk_low", c1, 1'b0);
    check("n1_tick", t1, 1'b1);
    at(17);
    check("n1_clk_high", c1, 1'b1);
    check("n2_first_rise", c2, 1'b1);
    check("n2_tick_1", t2, 1'b1);
    check("n3_first_rise", c3, 1'b1);
    check("n3_tick_1", t3, 1'b1);
    check("n5_low_17", c5, 1'b0);
    check("n10_low_17", c10, 1'b0);
    at(27);
    check("n2_fall", c2, 1'b0);
    check("n2_tick_0", t2, 1'b0);
    check("n3_tick_0", t3, 1'b0);
    check("n5_rise", c5, 1'b1);
    check("n5_tick", t5, 1'b1);
    at(29);
    check("n3_high_29", c3, 1'b1);
    at(31);
    check("n3_negedge_fall", c3, 1'b0);
    at(37);
    check("n2_rise_2", c2, 1'b1);
    check("n2_tick_2", t2, 1'b1);
    check("n5_high_37", c5, 1'b1);
    check("n5_tick_done", t5, 1'b0);
    at(44);
    check("n3_low_44", c3, 1'b0);
    at(46);
    check("n3_rise_2", c3, 1'b1);
    at(49);
    check("n5_high_49", c5, 1'b1);
    at(51);
    check("n5_negedge_fall", c5, 1'b0);
    at(54);
    check("n10_low_54", c10, 1'b0);
    check("n10_tick_54", t10, 1'b0);
    at(56);
    check("n10_rise", c10, 1'b1);
    check("n10_tick_56", t10, 1'b1);
    at(64);
    check("n10_tick_64", t10, 1'b1);
    at(66);
    check("n10_tick_66", t10, 1'b0);
    check("n10_high_66", c10, 1'b1);
    at(74);
    check("n5_low_74", c5, 1'b0);
    at(76);
    check("n5_rise_2", c5, 1'b1);
    check("n5_tick_2", t5, 1'b1);
    at(99);
    check("n5_high_99", c5, 1'b1);
    at(101);
    check("n5_fall_2", c5, 1'b0);
    at(104);
    check("n10_high_104", c10, 1'b1);
    at(106);
    check("n10_fall", c10, 1'b0);
    check("n10_tick_106", t10, 1'b0);
    at(154);
    check("n10_low_154", c10, 1'b0);
    at(156);
    check("n10_rise_2", c10, 1'b1);
    check("n10_tick_156", t10, 1'b1);
    at(166);
    check("n10_tick_166", t10, 1'b0);
    at(204);
    check("n10_high_204", c10, 1'b1);
    at(206);
    check("n10_fall_2", c10, 1'b0);

    // Mid-period reset while the N=10 output is high (high 255..305).
    at(279);
    check("n10_high_279", c10, 1'b1);
    at(282);
    rst = 1'b0;
    #0.0;
    at(283);
    check("async_rst_c10", c10, 1'b0);
    check("async_rst_t10", t10, 1'b0);
    check("async_rst_c5",  c5,  1'b0);
    check("async_rst_c1",  c1,  1'b0);
    check("async_rst_t1",  t1,  1'b0);
    at(290);
    rst = 1'b1;
    at(294);
    check("rel_t1", t1, 1'b1);
    at(297);
    check("rel_c1", c1, 1'b1);
    check("rel_n2_rise", c2, 1'b1);
    check("rel_n10_low_297", c10, 1'b0);
    at(303);
    check("rel_n5_low_303", c5, 1'b0);
    at(307);
    check("rel_n5_rise", c5, 1'b1);
    check("rel_n2_fall", c2, 1'b0);
    at(334);
    check("rel_n10_low_334", c10, 1'b0);
    at(336);
    check("rel_n10_rise", c10, 1'b1);
    check("rel_n10_tick", t10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
# clock_divider

Parameterised integer clock divider that derives a slower clock from the system clock `clk`. It produces a divided clock with exactly 50% duty cycle for even and odd factors, plus a one-cycle `tick` strobe aligned to each divided-clock rising edge. It sits at the clocking boundary and feeds slow peripherals, sample strobes and debug logic.

## Interface
- `DIV_FACTOR`, default 10: integer division ratio N; output period = N `clk` periods; legal range 1 to 65535; any value outside this range is an elaboration-time error.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: asynchronous, active-low reset (0 = reset asserted); assertion takes effect immediately, release is sampled by `clk`.
- `clk_out` output 1: divided clock, N·T period, 50% duty.
- `tick` output 1: registered strobe, high for exactly one `clk` period starting at each `clk_out` rising edge.

## Operation
- Internal counter `cnt`, width max(1, $clog2(N)), counts 0..N-1 on each `clk` rising edge and wraps N-1 -> 0.
- Let H = floor(N/2).
- Even N >= 2:
  - `clk_out` rises on the posedge where `cnt` advances H-1 -> H.
  - It falls on the posedge where `cnt` wraps N-1 -> 0.
  - High and low phases are each H periods.
- Odd N >= 3:
  - `clk_out` rises on the posedge where `cnt` advances H-1 -> H.
  - It stays high exactly N/2 periods and falls on the `clk` falling edge in the middle of the wrap cycle.
  - Low phase is N/2 periods. This requires one negedge-clocked flop; `clk_out` is a combination of glitch-free registered signals.
- N = 1: `clk_out` follows `clk` while `rst` = 1 and is forced to 0 while `rst` = 0; `tick` is constantly 1 while `rst` = 1.
- `tick` is high for one full `clk` period after each `clk_out` rising edge and is low otherwise (N >= 2).
- No enable and no runtime ratio change; N is fixed at elaboration.

## Timing
- Reset values while `rst` = 0: `cnt` = 0, `clk_out` = 0, `tick` = 0, negedge flop = 0. These are reached asynchronously and independent of `clk`.
- After `rst` is released, the first `clk` posedge moves `cnt` 0 -> 1.
- The first `clk_out` rise occurs on the H-th posedge after release (N >= 2). The sequence then repeats every N posedges.
- Reset asserted mid-period: `clk_out` drops to 0 immediately; a shortened high pulse is permitted. After release the sequence restarts from the beginning; no phase is retained.
- Release coincident with a `clk` edge: that edge is treated as the first counting edge or is ignored, but behaviour must be deterministic per implementation. Benches release `rst` away from edges.

## Test plan
- N = 10, `clk` period 10 ns with rising edges at 5, 15, 25 ns, `rst` 0 -> 1 at 10 ns -> `clk_out` = 0 until 55 ns; rises at 55; falls at 105; rises at 155; falls at 205. `tick` is high 55–65 ns and 155–165 ns.
- N = 5, same clock and release -> `clk_out` rises at 25 ns, falls at 50 ns (negedge), rises at 75 ns, falls at 100 ns. Period 50 ns, duty exactly 50%.
- N = 2 -> `clk_out` rises on the first posedge after release and toggles on every subsequent posedge. `tick` is high every other cycle.
- N = 1 -> `clk_out` equals `clk` while `rst` = 1 and is 0 while `rst` = 0. `tick` = `rst`.
- N = 10, drive `rst` low at 80 ns while `clk_out` = 1 -> `clk_out`, `tick` and `cnt` go to 0 at 80 ns without waiting for a clock edge. Release at 90 ns -> first rise at 135 ns.
- N = 0 or N = 65536 -> elaboration fails with an error.
